// File: rtl/pulse_interval_monitor.sv
// Counts synchronised rising edges of an asynchronous pulse line over a fixed window
// and tracks min/max pulse spacing; results are latched at window end and read via sel.
module pulse_interval_monitor #(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] data_out,
    output logic             win_valid,
    output logic             overflow
);
    localparam int                WCNT_W = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  ONES   = '1;
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LATCH = 2'd2} state_t;

    state_t            state_reg;
    logic              s1_reg, s2_reg, s3_reg;
    logic              evt;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [CNT_W-1:0]  pcnt_reg, gcnt_reg, min_reg, max_reg;
    logic              seen_reg;
    logic [CNT_W-1:0]  lat_cnt_reg, lat_min_reg, lat_max_reg;
    logic              win_valid_reg, overflow_reg;

    logic              fresh, live_run;
    logic [CNT_W-1:0]  base_pcnt, base_gcnt, base_min, base_max, gap;
    logic              base_seen;
    logic [CNT_W-1:0]  pcnt_next, gcnt_next, min_next, max_next;
    logic              seen_next, sat_next;

    assign evt       = s2_reg & ~s3_reg;
    assign win_valid = win_valid_reg;
    assign overflow  = overflow_reg;
    assign live_run  = ~clear & enable & ((state_reg == RUN) | (state_reg == LATCH));

    // In LATCH the new window starts from cleared values, so an event there is its first pulse
    always_comb begin
        fresh     = (state_reg == LATCH);
        base_pcnt = fresh ? '0   : pcnt_reg;
        base_gcnt = fresh ? '0   : gcnt_reg;
        base_min  = fresh ? ONES : min_reg;
        base_max  = fresh ? '0   : max_reg;
        base_seen = fresh ? 1'b0 : seen_reg;
        gap       = (base_gcnt == ONES) ? ONES : base_gcnt + ONE;
        pcnt_next = base_pcnt;
        gcnt_next = base_gcnt;
        min_next  = base_min;
        max_next  = base_max;
        seen_next = base_seen;
        sat_next  = 1'b0;
        if (evt) begin
            if (base_pcnt == ONES) sat_next = 1'b1;
            else                   pcnt_next = base_pcnt + ONE;
            if (base_seen) begin
                if (gap < base_min) min_next = gap;
                if (gap > base_max) max_next = gap;
            end
            gcnt_next = '0;
            seen_next = 1'b1;
        end else begin
            if (base_gcnt == ONES) sat_next = 1'b1;
            else                   gcnt_next = base_gcnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            s3_reg        <= 1'b0;
            wcnt_reg      <= '0;
            pcnt_reg      <= '0;
            gcnt_reg      <= '0;
            min_reg       <= ONES;
            max_reg       <= '0;
            seen_reg      <= 1'b0;
            lat_cnt_reg   <= '0;
            lat_min_reg   <= ONES;
            lat_max_reg   <= '0;
            win_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            s1_reg        <= pulse_in;
            s2_reg        <= s1_reg;
            s3_reg        <= s2_reg;
            win_valid_reg <= 1'b0;
            if (live_run) begin
                pcnt_reg <= pcnt_next;
                gcnt_reg <= gcnt_next;
                min_reg  <= min_next;
                max_reg  <= max_next;
                seen_reg <= seen_next;
                if (sat_next) overflow_reg <= 1'b1;
            end else begin
                pcnt_reg <= '0;
                gcnt_reg <= '0;
                min_reg  <= ONES;
                max_reg  <= '0;
                seen_reg <= 1'b0;
            end
            if (clear) begin
                state_reg    <= enable ? RUN : IDLE;
                wcnt_reg     <= '0;
                lat_cnt_reg  <= '0;
                lat_min_reg  <= ONES;
                lat_max_reg  <= '0;
                overflow_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        wcnt_reg <= '0;
                        if (enable) state_reg <= RUN;
                    end
                    RUN: begin
                        if (!enable) begin
                            state_reg <= IDLE;
                            wcnt_reg  <= '0;
                        end else if (wcnt_reg == WLAST) begin
                            // Latch the closing values (including this cycle's event) so the
                            // results are already readable while win_valid is high
                            state_reg     <= LATCH;
                            wcnt_reg      <= '0;
                            lat_cnt_reg   <= pcnt_next;
                            lat_min_reg   <= min_next;
                            lat_max_reg   <= max_next;
                            win_valid_reg <= 1'b1;
                        end else begin
                            wcnt_reg <= wcnt_reg + WCNT_W'(1);
                        end
                    end
                    LATCH: begin
                        wcnt_reg  <= '0;
                        state_reg <= enable ? RUN : IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (sel)
            2'd0:    data_out = lat_cnt_reg;
            2'd1:    data_out = lat_min_reg;
            2'd2:    data_out = lat_max_reg;
            default: begin
                data_out[2]   = overflow_reg;
                data_out[1:0] = state_reg;
            end
        endcase
    end
endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Self-checking bench for pulse_interval_monitor: table-driven windows, hand-written
// boundary sequences and randomized pulse trains against an event-list reference model.
module tb_pulse_interval_monitor;
    localparam int W = 64;

    logic        clk = 1'b0;
    logic        rst_n, pulse_in, enable, clear;
    logic [1:0]  sel;
    logic [15:0] data_out;
    logic        win_valid, overflow;

    logic        pulse4, enable4, clear4;
    logic [1:0]  sel4;
    logic [3:0]  data4;
    logic        wv4, ov4;

    always #5 clk = ~clk;

    pulse_interval_monitor #(.WINDOW(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .enable(enable), .clear(clear),
        .sel(sel), .data_out(data_out), .win_valid(win_valid), .overflow(overflow)
    );

    pulse_interval_monitor #(.WINDOW(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse4), .enable(enable4), .clear(clear4),
        .sel(sel4), .data_out(data4), .win_valid(wv4), .overflow(ov4)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] exp;
    } rd_vec_t;

    typedef struct packed {
        logic [8:0]      first;   // 256 or more means no pulse at all
        logic [2:0]      ngaps;
        logic [4:0][7:0] gaps;
        logic [15:0]     exp_cnt;
        logic [15:0]     exp_min;
        logic [15:0]     exp_max;
    } win_vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          edge_n   = 0;
    bit          p_hist [0:4095];
    bit          sched  [0:1023];
    logic [15:0] got_cnt[$], got_min[$], got_max[$];
    rd_vec_t     rst_tab[4];
    win_vec_t    vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (edge_n < 4096) p_hist[edge_n] = pulse_in;
        #1;
    endtask

    task automatic rd(input logic [1:0] s, output logic [15:0] v);
        sel = s;
        #1;
        v = data_out;
    endtask

    task automatic check_reset(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            rd(rst_tab[i].sel, v);
            check($sformatf("%s sel%0d", tag, i), v, rst_tab[i].exp);
        end
        check({tag, " win_valid"}, win_valid, 1'b0);
        check({tag, " overflow"}, overflow, 1'b0);
    endtask

    // Reference: list the edges at which a rising edge of pulse_in is seen (two edges of
    // synchroniser delay), then derive count and spacing within the window [lo, hi].
    task automatic win_expect(input int lo, input int hi,
                              output logic [15:0] c, output logic [15:0] mn, output logic [15:0] mx);
        int ev[$];
        int g;
        for (int t = lo; t <= hi; t++)
            if (p_hist[t-2] && !p_hist[t-3]) ev.push_back(t);
        c  = 16'(ev.size());
        mn = 16'hFFFF;
        mx = 16'h0000;
        for (int i = 1; i < ev.size(); i++) begin
            g = ev[i] - ev[i-1];
            if (g < int'(mn)) mn = 16'(g);
            if (g > int'(mx)) mx = 16'(g);
        end
    endtask

    task automatic clr_sched();
        for (int i = 0; i < 1024; i++) sched[i] = 1'b0;
    endtask

    task automatic idle_wait();
        enable   = 1'b0;
        pulse_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic quiesce();
        enable   = 1'b0;
        pulse_in = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();
    endtask

    // Raises enable, plays sched[] one entry per edge and checks win_valid every cycle.
    // At each window end the results are compared with the model and queued for callers.
    task automatic run_sched(input int n, input int drop_j);
        int          e0;
        bit          exp_wv;
        logic [15:0] v0, v1, v2, v3, ec, emn, emx;
        got_cnt.delete();
        got_min.delete();
        got_max.delete();
        enable = 1'b1;
        e0     = edge_n + 1;
        for (int j = 0; j < n; j++) begin
            if (j == drop_j) enable = 1'b0;
            pulse_in = sched[j];
            tick();
            exp_wv = (drop_j < 0 || j < drop_j) && j >= W && ((j - W) % (W + 1) == 0);
            check($sformatf("win_valid j=%0d", j), win_valid, exp_wv);
            if (exp_wv) begin
                win_expect((j == W) ? e0 + 1 : e0 + j - W, e0 + j, ec, emn, emx);
                rd(2'd0, v0);
                rd(2'd1, v1);
                rd(2'd2, v2);
                rd(2'd3, v3);
                check("model count", v0, ec);
                check("model min", v1, emn);
                check("model max", v2, emx);
                check("status latch", v3, 16'h0002);
                check("no overflow", overflow, 1'b0);
                got_cnt.push_back(v0);
                got_min.push_back(v1);
                got_max.push_back(v2);
                $display("window end j=%0d count=%0d min=%0h max=%0h (model %0d %0h %0h)",
                         j, v0, v1, v2, ec, emn, emx);
            end
        end
        pulse_in = 1'b0;
    endtask

    function automatic win_vec_t mk(input int first, input int ng, input int g0, input int g1,
                                    input int g2, input int g3, input int g4,
                                    input int c, input int mn, input int mx);
        win_vec_t v;
        v.first   = 9'(first);
        v.ngaps   = 3'(ng);
        v.gaps[0] = 8'(g0);
        v.gaps[1] = 8'(g1);
        v.gaps[2] = 8'(g2);
        v.gaps[3] = 8'(g3);
        v.gaps[4] = 8'(g4);
        v.exp_cnt = 16'(c);
        v.exp_min = 16'(mn);
        v.exp_max = 16'(mx);
        return v;
    endfunction

    task automatic load_vec(input win_vec_t v);
        int k;
        clr_sched();
        if (v.first < 256) begin
            k = int'(v.first);
            sched[k] = 1'b1;
            for (int i = 0; i < int'(v.ngaps); i++) begin
                k += int'(v.gaps[i]);
                sched[k] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        int          j;
        rst_tab[0] = '{2'd0, 16'h0000};
        rst_tab[1] = '{2'd1, 16'hFFFF};
        rst_tab[2] = '{2'd2, 16'h0000};
        rst_tab[3] = '{2'd3, 16'h0000};
        vecs[0] = mk(5,   5, 10, 10, 10, 10, 10, 6, 16'h000A, 16'h000A);
        vecs[1] = mk(5,   3, 3, 7, 5, 0, 0,      4, 16'h0003, 16'h0007);
        vecs[2] = mk(20,  0, 0, 0, 0, 0, 0,      1, 16'hFFFF, 16'h0000);
        vecs[3] = mk(10,  1, 52, 0, 0, 0, 0,     2, 16'h0034, 16'h0034);
        vecs[4] = mk(300, 0, 0, 0, 0, 0, 0,      0, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 4096; i++) p_hist[i] = 1'b0;
        clr_sched();

        rst_n = 1'b0; pulse_in = 1'b0; enable = 1'b0; clear = 1'b0; sel = 2'd0;
        pulse4 = 1'b0; enable4 = 1'b0; clear4 = 1'b0; sel4 = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Narrow counters: a silent line saturates the gap counter and sets sticky overflow
        enable4 = 1'b1;
        repeat (11) tick();
        check("cnt4 overflow early", ov4, 1'b0);
        repeat (9) tick();
        check("cnt4 overflow set", ov4, 1'b1);
        check("cnt4 status", data4, 4'b0101);
        repeat (10) tick();
        check("cnt4 overflow sticky", ov4, 1'b1);
        clear4  = 1'b1;
        enable4 = 1'b0;
        tick();
        clear4 = 1'b0;
        check("cnt4 overflow cleared", ov4, 1'b0);
        check("cnt4 status cleared", data4, 4'b0000);

        for (int i = 0; i < 5; i++) begin
            quiesce();
            load_vec(vecs[i]);
            run_sched(W + 2, -1);
            check($sformatf("vec%0d windows", i), got_cnt.size(), 1);
            if (got_cnt.size() == 1) begin
                check($sformatf("vec%0d count", i), got_cnt[0], vecs[i].exp_cnt);
                check($sformatf("vec%0d min", i), got_min[0], vecs[i].exp_min);
                check($sformatf("vec%0d max", i), got_max[0], vecs[i].exp_max);
            end
        end

        // A pulse whose event lands in the LATCH cycle opens the next window
        quiesce();
        clr_sched();
        sched[10] = 1'b1;
        sched[63] = 1'b1;
        sched[85] = 1'b1;
        run_sched(2 * W + 3, -1);
        check("latch-evt windows", got_cnt.size(), 2);
        if (got_cnt.size() == 2) begin
            check("latch-evt w1 count", got_cnt[0], 16'd1);
            check("latch-evt w1 min", got_min[0], 16'hFFFF);
            check("latch-evt w1 max", got_max[0], 16'h0000);
            check("latch-evt w2 count", got_cnt[1], 16'd2);
            check("latch-evt w2 min", got_min[1], 16'd22);
            check("latch-evt w2 max", got_max[1], 16'd22);
        end

        // Dropping enable mid-window discards live values and keeps the latched ones
        idle_wait();
        clr_sched();
        sched[5]  = 1'b1;
        sched[15] = 1'b1;
        run_sched(100, 31);
        rd(2'd3, v);
        check("abort status idle", v, 16'h0000);
        rd(2'd0, v);
        check("abort kept count", v, 16'd2);
        rd(2'd1, v);
        check("abort kept min", v, 16'd22);
        rd(2'd2, v);
        check("abort kept max", v, 16'd22);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_reset("clear");

        // Random pulse train over six consecutive windows
        quiesce();
        clr_sched();
        j = int'($urandom_range(0, 5));
        while (j < 400) begin
            for (int h = int'($urandom_range(1, 3)); h > 0 && j < 400; h--) begin
                sched[j] = 1'b1;
                j++;
            end
            j += int'($urandom_range(1, 12));
        end
        run_sched(400, -1);
        check("random windows", got_cnt.size(), 6);

        // Reset in the middle of a window returns everything to reset values at once
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
